// File: rtl/mult_issue_arbiter.sv
// -----------------------------------------------------------------------------
// mult_issue_arbiter
//
// Shares one pipelined 64x64 multiplier among N_REQ requesters. A round-robin
// arbiter picks at most one requester per cycle and launches its operands into
// registered mul_x/mul_y. A {valid, id} tag travels alongside the multiplier
// for MUL_LAT cycles. When the tag leaves the pipeline, the product is written
// into a result FIFO. A registered output stage presents the FIFO head to the
// consumer.
//
// Flow control is credit based. Each grant takes one credit and each consumed
// result returns one. At most FIFO_DEPTH operations are in flight or buffered,
// so a product arriving from the multiplier always has a FIFO slot.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   req_valid    per-requester operand valid            [N_REQ]
//   req_ready    per-requester grant (combinational)    [N_REQ]
//   req_x/req_y  packed operands, requester i in [64*i+63:64*i]
//   mul_x/mul_y  registered operands to the shared multiplier
//   mul_product  product returned by the shared multiplier
//   res_valid    result available
//   res_ready    consumer accepts result
//   res_id       index of the requester that issued the result
//   res_product  128-bit unsigned product
//   busy         any operation in flight or buffered
// -----------------------------------------------------------------------------
module mult_issue_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MUL_LAT    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*64-1:0]      req_x,
    input  logic [N_REQ*64-1:0]      req_y,
    output logic [63:0]              mul_x,
    output logic [63:0]              mul_y,
    input  logic [127:0]             mul_product,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [127:0]             res_product,
    output logic                     busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0]  CREDIT_MAX = CW'(FIFO_DEPTH);
    localparam logic [IDW-1:0] LAST_ID    = IDW'(N_REQ - 1);

    // Pointer that follows a grant to requester id, wrapping at N_REQ.
    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        logic [IDW-1:0] nxt;
        if (id == LAST_ID) begin
            nxt = {IDW{1'b0}};
        end else begin
            nxt = id + IDW'(1);
        end
        return nxt;
    endfunction

    // Arbitration and credit
    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] grant_idx_s;
    logic           grant_s;
    logic           credit_ok_s;
    logic [CW-1:0]  out_cnt_r;
    logic [CW-1:0]  out_cnt_next_s;

    // Tag pipeline alongside the multiplier
    logic           tag_vld_r [MUL_LAT];
    logic [IDW-1:0] tag_id_r  [MUL_LAT];
    logic           push_s;

    // Result FIFO and output stage
    logic [127:0]   fifo_prod_r [FIFO_DEPTH];
    logic [IDW-1:0] fifo_id_r   [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  fifo_cnt_r;
    logic           out_load_s;
    logic           pop_s;

    // Outstanding counts every granted operation until its result is consumed.
    // Therefore in-flight plus buffered results can never exceed the FIFO size.
    assign credit_ok_s = (out_cnt_r < CREDIT_MAX);
    assign pop_s       = res_valid && res_ready;
    assign push_s      = tag_vld_r[MUL_LAT-1];
    // Refill the output stage when it is empty or being drained this cycle.
    assign out_load_s  = (fifo_cnt_r != {CW{1'b0}}) && (!res_valid || res_ready);

    // Round-robin search starting at ptr_r. The first valid requester wins, and only while credit remains.
    always_comb begin
        int   idx_v;
        logic pick_v;
        idx_v       = 0;
        pick_v      = 1'b0;
        req_ready   = {N_REQ{1'b0}};
        grant_s     = 1'b0;
        grant_idx_s = {IDW{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            idx_v            = (int'(ptr_r) + k) % N_REQ;
            pick_v           = credit_ok_s && !grant_s && req_valid[idx_v];
            req_ready[idx_v] = req_ready[idx_v] | pick_v;
            grant_idx_s      = pick_v ? IDW'(idx_v) : grant_idx_s;
            grant_s          = grant_s | pick_v;
        end
    end

    // Next outstanding count. A grant and a pop in the same cycle cancel out.
    always_comb begin
        out_cnt_next_s = out_cnt_r;
        case ({grant_s, pop_s})
            2'b10:   out_cnt_next_s = out_cnt_r + CW'(1);
            2'b01:   out_cnt_next_s = out_cnt_r - CW'(1);
            default: out_cnt_next_s = out_cnt_r;
        endcase
    end

    // Operand launch registers and round-robin pointer. Both hold when there is no grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= {IDW{1'b0}};
            mul_x <= 64'd0;
            mul_y <= 64'd0;
        end else if (grant_s) begin
            ptr_r <= next_ptr(grant_idx_s);
            mul_x <= req_x[64*grant_idx_s +: 64];
            mul_y <= req_y[64*grant_idx_s +: 64];
        end
    end

    // Tag shift register. Stage 0 is loaded on the same edge as the operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_vld_r[k] <= 1'b0;
                tag_id_r[k]  <= {IDW{1'b0}};
            end
        end else begin
            tag_vld_r[0] <= grant_s;
            tag_id_r[0]  <= grant_idx_s;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_vld_r[k] <= tag_vld_r[k-1];
                tag_id_r[k]  <= tag_id_r[k-1];
            end
        end
    end

    // Result FIFO. A product is captured when its tag reaches the last stage.
    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_prod_r[wr_ptr_r] <= mul_product;
                fifo_id_r[wr_ptr_r]   <= tag_id_r[MUL_LAT-1];
                wr_ptr_r              <= wr_ptr_r + AW'(1);
            end
            if (out_load_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, out_load_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Registered result stage. It holds its contents while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            res_id      <= {IDW{1'b0}};
            res_product <= 128'd0;
        end else if (out_load_s) begin
            res_valid   <= 1'b1;
            res_id      <= fifo_id_r[rd_ptr_r];
            res_product <= fifo_prod_r[rd_ptr_r];
        end else if (pop_s) begin
            res_valid   <= 1'b0;
        end
    end

    // Credit counter and the registered busy flag derived from its next value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_cnt_r <= {CW{1'b0}};
            busy      <= 1'b0;
        end else begin
            out_cnt_r <= out_cnt_next_s;
            busy      <= (out_cnt_next_s != {CW{1'b0}});
        end
    end

endmodule

// File: tb/tb_mult_issue_arbiter.sv
module tb_mult_issue_arbiter;

    localparam int N_REQ      = 4;
    localparam int MUL_LAT    = 4;
    localparam int FIFO_DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [255:0] req_x;
    logic [255:0] req_y;
    logic [63:0]  mul_x;
    logic [63:0]  mul_y;
    logic [127:0] mul_product;
    logic         res_valid;
    logic         res_ready;
    logic [1:0]   res_id;
    logic [127:0] res_product;
    logic         busy;

    mult_issue_arbiter #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .mul_x(mul_x), .mul_y(mul_y),
        .mul_product(mul_product), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_product(res_product), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared multiplier: product of the launched operands, sampled MUL_LAT edges after launch
    logic [127:0] mp0, mp1, mp2;
    always @(posedge clk) begin
        mp0 <= {64'd0, mul_x} * {64'd0, mul_y};
        mp1 <= mp0;
        mp2 <= mp1;
    end
    assign mul_product = mp2;

    // Reference model: expected results in grant order, each with the cycle it becomes visible
    typedef struct {
        int           id;
        logic [127:0] prod;
        int           avail;
    } exp_t;

    exp_t q[$];
    int   ptr_m = 0;
    int   outst_m = 0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   grants_m = 0;
    int   pops_dut = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Per-cycle compare of the DUT against the model, followed by the model update for the coming edge
    task automatic check();
        logic [3:0] er;
        logic       ev;
        logic       found;
        int         idx;
        int         gidx;
        exp_t       e;
        if (!rst_n) begin
            ptr_m   = 0;
            outst_m = 0;
            q.delete();
            cyc++;
            return;
        end
        er    = 4'b0000;
        found = 1'b0;
        gidx  = 0;
        if (outst_m < FIFO_DEPTH) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (ptr_m + k) % N_REQ;
                if (!found && req_valid[idx]) begin
                    er[idx] = 1'b1;
                    found   = 1'b1;
                    gidx    = idx;
                end
            end
        end
        chk("req_ready", req_ready, er);
        ev = (q.size() > 0) && (q[0].avail <= cyc);
        chk("res_valid", res_valid, ev);
        if (ev) begin
            chk("res_id", res_id, q[0].id);
            chk("res_product", res_product, q[0].prod);
        end
        chk("busy", busy, outst_m != 0);
        if (res_valid && res_ready) pops_dut++;
        if (ev && res_ready) begin
            void'(q.pop_front());
            outst_m--;
        end
        if (found) begin
            e.id    = gidx;
            e.prod  = {64'd0, req_x[64*gidx +: 64]} * {64'd0, req_y[64*gidx +: 64]};
            e.avail = cyc + MUL_LAT + 2;
            q.push_back(e);
            ptr_m = (gidx + 1) % N_REQ;
            outst_m++;
            grants_m++;
        end
        cyc++;
    endtask

    // One clock cycle: compare mid-cycle, then move to just after the next rising edge
    task automatic step();
        #2;
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        req_valid = 4'b0000;
        res_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Single isolated operation with a hand-computed expected product and latency
    task automatic directed(input int id, input logic [63:0] x, input logic [63:0] y,
                            input logic [127:0] expp, input string nm);
        int n;
        res_ready          = 1'b1;
        req_valid          = 4'b0000;
        req_valid[id]      = 1'b1;
        req_x[64*id +: 64] = x;
        req_y[64*id +: 64] = y;
        #1;
        chk({nm, " grant"}, req_ready, 128'd1 << id);
        step();
        req_valid = 4'b0000;
        chk({nm, " mul_x"}, mul_x, x);
        chk({nm, " mul_y"}, mul_y, y);
        n = 1;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        chk({nm, " latency"}, n, MUL_LAT + 2);
        chk({nm, " product"}, res_product, expp);
        chk({nm, " id"}, res_id, id);
        step();
    endtask

    initial begin
        int g;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_x     = 256'd0;
        req_y     = 256'd0;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("reset res_valid", res_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset res_id", res_id, 0);
        chk("reset res_product", res_product, 0);
        chk("reset mul_x", mul_x, 0);
        chk("reset req_ready", req_ready, 0);

        // Single operations and arithmetic boundaries
        directed(0, 64'd123456789, 64'd20, 128'h932C05A4, "single");
        directed(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 128'hFFFFFFFFFFFFFFFE0000000000000001, "maxmax");
        directed(3, 64'd0, 64'hDEAD_BEEF_0123_4567, 128'd0, "zero");
        drain(4);

        // Contention: every requester always valid
        reset_dut();
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            req_x[64*i +: 64] = rnd64();
            req_y[64*i +: 64] = rnd64();
        end
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("rr order", req_ready, 128'd1 << (k % 4));
            step();
        end
        drain(20);

        // Backpressure: the consumer stalls, so grants stop once the credit is used up
        reset_dut();
        res_ready = 1'b0;
        req_valid = 4'b0010;
        g = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (req_ready[1]) g++;
            step();
        end
        chk("bp grants", g, FIFO_DEPTH);
        chk("bp stalled", req_ready, 0);
        res_ready = 1'b1;
        for (int k = 0; k < 40; k++) step();
        drain(30);
        chk("bp drained busy", busy, 0);

        // Reset while three operations are in flight
        reset_dut();
        res_ready = 1'b1;
        req_valid = 4'b0111;
        step();
        step();
        step();
        reset_dut();
        #1;
        chk("midrst res_valid", res_valid, 0);
        chk("midrst busy", busy, 0);
        chk("midrst mul_x", mul_x, 0);
        for (int k = 0; k < 12; k++) step();
        req_valid = 4'hF;
        #1;
        chk("midrst ptr", req_ready, 1);
        step();
        drain(20);

        // Random traffic
        reset_dut();
        grants_m = 0;
        pops_dut = 0;
        for (int c = 0; c < 60000 && grants_m < 10000; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                req_x[64*i +: 64] = rnd64();
                req_y[64*i +: 64] = rnd64();
            end
            step();
        end
        drain(40);
        chk("random result count", pops_dut, grants_m);
        chk("random final busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_issue_arbiter.md
MULT_ISSUE_ARBITER -- requirements
Module: mult_issue_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter MUL_LAT, default 4: fixed multiplier latency in cycles, operand launch to product, ≥1.
REQ-003 Parameter FIFO_DEPTH, default 8: result buffer entries; power of two, ≥2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  N_REQ  per-requester operand valid.
REQ-007 req_ready  out  N_REQ  per-requester accept (grant).
REQ-008 req_x, req_y  in  N_REQ*64 each  packed operands; requester i occupies bits [64*i+63:64*i].
REQ-009 mul_x, mul_y  out  64 each  registered operands to the shared karatsuba64 instance.
REQ-010 mul_product  in  128  product from the shared multiplier.
REQ-011 res_valid  out  1  result available.
REQ-012 res_ready  in  1  consumer accepts result.
REQ-013 res_id  out  clog2(N_REQ)  index of the originating requester.
REQ-014 res_product  out  128  unsigned x*y.
REQ-015 busy  out  1  high while any operation is in flight or buffered.

Function
REQ-016 Handshake: a transfer occurs on requester i when req_valid[i] and req_ready[i] are both high at a rising edge; res likewise on res_valid and res_ready.
REQ-017 At most one req_ready bit is high per cycle; req_ready is combinational from req_valid, the RR pointer and credit; req_ready[i] never high while req_valid[i] is low.
REQ-018 Round-robin: search starts at index ptr and wraps mod N_REQ; first valid requester is granted; after a grant to i, ptr becomes (i+1) mod N_REQ; ptr is unchanged with no grant.
REQ-019 Credit: outstanding = in-flight count + FIFO count; grant only when outstanding < FIFO_DEPTH; same-cycle grant and result pop leave outstanding unchanged.
REQ-020 On grant at cycle t, the granted req_x/req_y are loaded into mul_x/mul_y at the edge ending t; mul_x/mul_y hold their value when no grant occurs.
REQ-021 Tag pipeline: MUL_LAT-stage shift register of {valid, id}, entered at the same edge as mul_x/mul_y; mul_product is sampled when the last stage is valid.
REQ-022 Sampled product and id are pushed into the FIFO at that edge; the push never fails because of REQ-019.
REQ-023 Latency: with an empty FIFO, res_valid rises MUL_LAT+2 cycles after the accepting edge; throughput one operation per cycle when res_ready stays high.
REQ-024 Results leave strictly in grant order; res_id/res_product remain stable while res_valid is high and res_ready is low.
REQ-025 Simultaneous push and pop at FIFO full or empty are both honoured; pop of an empty FIFO is ignored; FIFO pointers wrap mod FIFO_DEPTH.
REQ-026 busy = (outstanding != 0).
REQ-027 Arithmetic is unsigned; the block does not modify the product; operands are 64 bits and results 128 bits, with no truncation.

Reset
REQ-028 While rst_n is low at a rising edge: ptr=0, tag pipeline valids cleared, FIFO emptied, counters 0, mul_x=mul_y=0.
REQ-029 Outputs after reset: req_ready=0 unless valid/credit allow, res_valid=0, res_id=0, res_product=0, busy=0.
REQ-030 Reset mid-operation discards all in-flight and buffered results; no result from before reset appears afterwards.

Verification
REQ-031 Single op: req0 x=123456789, y=20, res_ready=1 -> res_valid after MUL_LAT+2 cycles, res_product=0x932C05A4, res_id=0.
REQ-032 Contention: all four req_valid high continuously from reset, res_ready=1 -> grants 0,1,2,3,0,...; res_id appears in the same order, with one result per cycle.
REQ-033 Backpressure: res_ready=0, req1 always valid -> exactly FIFO_DEPTH grants, then req_ready=0; raising res_ready resumes grants with no loss or duplication.
REQ-034 Boundary: x=y=0xFFFFFFFFFFFFFFFF -> res_product=0xFFFFFFFFFFFFFFFE0000000000000001; x=0 -> 0.
REQ-035 Reset mid-flight: 3 ops issued, rst_n low for 1 cycle -> res_valid=0 and busy=0 afterwards, no stale results, ptr=0.
REQ-036 Random: 10k ops with random valids, res_ready and operands -> every result matches a golden model, in order, with correct id.
